// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage: result and flags are registered one cycle after acceptance.
// A skid entry absorbs one accept under downstream stall; in_ready is registered, so out_ready never reaches it combinationally.
module alu_exec_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow,
   output logic              illegal,
   output logic [CNT_W-1:0]  op_count
);

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic              zero;
      logic              ovf;
      logic              ill;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_t;

   state_t            state;
   state_t            state_nxt;
   entry_t            main_q;
   entry_t            skid_q;
   entry_t            alu_entry;
   logic              in_ready_q;
   logic [CNT_W-1:0]  count_q;
   logic              in_fire;
   logic              out_fire;
   logic              load_main_new;
   logic              load_main_skid;
   logic              load_skid;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic              sign_a;
   logic              sign_b;

   assign sum    = op_a + op_b;
   assign diff   = op_a - op_b;
   assign sign_a = op_a[DATA_W-1];
   assign sign_b = op_b[DATA_W-1];

   // Illegal codes fall through with res=0, which makes zero=1 automatically.
   always_comb begin
      alu_entry = '0;
      case (alu_ctrl)
         CTRL_AND: alu_entry.res = op_a & op_b;
         CTRL_OR:  alu_entry.res = op_a | op_b;
         CTRL_ADD: begin
            alu_entry.res = sum;
            alu_entry.ovf = (sign_a == sign_b) && (sum[DATA_W-1] != sign_a);
         end
         CTRL_SUB: begin
            alu_entry.res = diff;
            alu_entry.ovf = (sign_a != sign_b) && (diff[DATA_W-1] != sign_a);
         end
         CTRL_SLT: alu_entry.res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         CTRL_NOR: alu_entry.res = ~(op_a | op_b);
         default:  alu_entry.ill = 1'b1;
      endcase
      alu_entry.zero = (alu_entry.res == '0);
   end

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt     = ONE;
               load_main_new = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_new = 1'b1;
            end else if (in_fire) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_nxt      = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != TWO);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_new) begin
            main_q <= alu_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= alu_entry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (out_fire && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign result    = main_q.res;
   assign zero      = main_q.zero;
   assign overflow  = main_q.ovf;
   assign illegal   = main_q.ill;
   assign op_count  = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed corner cases, then randomized traffic against a queue-based model.
module tb_alu_exec_stage;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int CNT_MAX = 255;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
      logic        ill;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    alu_ctrl = 4'h0;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] result;
   logic          zero;
   logic          overflow;
   logic          illegal;
   logic [CW-1:0] op_count;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   fail_cnt = 0;
   exp_t q[$];
   bit   armed = 1'b0;
   int   accepted = 0;
   int   delivered = 0;
   int   exp_count = 0;

   alu_exec_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference ALU: signed math done in 64 bits, overflow = result outside 32-bit signed range.
   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa;
      longint sb;
      longint s;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.res = 32'd0;
      e.ov  = 1'b0;
      e.ill = 1'b0;
      case (c)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: begin
            s     = sa + sb;
            e.res = 32'(s);
            e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'b0110: begin
            s     = sa - sb;
            e.res = 32'(s);
            e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'b1100: e.res = ~(a | b);
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input bit iv, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit ordy);
      bit   exp_vld;
      bit   exp_rdy;
      exp_t e;
      in_valid  = iv;
      alu_ctrl  = c;
      op_a      = a;
      op_b      = b;
      out_ready = ordy;
      exp_vld = (q.size() != 0);
      exp_rdy = armed && (q.size() < 2);
      check("out_valid", out_valid, exp_vld);
      check("in_ready", in_ready, exp_rdy);
      check("op_count", op_count, exp_count);
      if (exp_vld && ordy) begin
         e = q.pop_front();
         check("result", result, e.res);
         check("flags_z_ov_ill", {zero, overflow, illegal}, {e.z, e.ov, e.ill});
         delivered++;
         if (exp_count < CNT_MAX) exp_count++;
      end
      if (iv && exp_rdy) begin
         q.push_back(model(c, a, b));
         accepted++;
      end
      @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
      q.delete();
      armed     = 1'b0;
      exp_count = 0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {zero, overflow, illegal}, 3'b000);
      check("rst_op_count", op_count, 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] codes [6];
      logic [3:0] c;
      int         start;
      int         cyc;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

      @(negedge clk);
      do_reset(2);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);
      check("post_rst_in_ready", in_ready, 1'b1);

      // Signed ADD overflow
      cycle(1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1);
      check("add_ovf_vld", out_valid, 1'b1);
      check("add_ovf_res", result, 32'h8000_0000);
      check("add_ovf_flags", {zero, overflow, illegal}, 3'b010);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);

      // SUB to zero, then signed SLT, back to back
      cycle(1, 4'b0110, 32'd5, 32'd5, 1);
      check("sub_res", result, 32'd0);
      check("sub_zero", zero, 1'b1);
      cycle(1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1);
      check("slt_res", result, 32'd1);
      check("slt_zero", zero, 1'b0);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);

      // Downstream stall fills the skid entry
      cycle(1, 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0);
      cycle(1, 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0);
      check("two_in_ready", in_ready, 1'b0);
      check("hold_res", result, 32'h00F0_000F);
      cycle(0, 4'h0, 32'd0, 32'd0, 0);
      check("hold_res_again", result, 32'h00F0_000F);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);
      check("skid_res", result, 32'hFFF0_0FFF);
      check("skid_in_ready", in_ready, 1'b1);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);

      // Undefined code
      cycle(1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1);
      check("ill_flags", {zero, overflow, illegal}, 3'b101);
      check("ill_res", result, 32'd0);
      cycle(0, 4'h0, 32'd0, 32'd0, 1);
      check("ill_count", op_count, 6);

      // Reset while both entries are occupied
      cycle(1, 4'b0010, 32'd1, 32'd2, 0);
      cycle(1, 4'b0010, 32'd3, 32'd4, 0);
      check("full_in_ready", in_ready, 1'b0);
      do_reset(1);
      repeat (3) cycle(0, 4'h0, 32'd0, 32'd0, 1);
      check("post_rst_result", result, 32'd0);

      // Random traffic
      start = accepted;
      cyc   = 0;
      while ((accepted - start) < 10000 && cyc < 40000) begin
         if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
         else                           c = codes[$urandom_range(0, 5)];
         cycle($urandom_range(0, 3) != 0, c, rand_operand(), rand_operand(),
               $urandom_range(0, 3) != 0);
         cyc++;
      end
      check("random_ops_done", (accepted - start) >= 10000, 1'b1);
      repeat (4) cycle(0, 4'h0, 32'd0, 32'd0, 1);
      check("final_count_sat", op_count, CNT_MAX);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
